// File: rtl/thermo_enc_pkg.sv
// Shared constants, types and helpers for the thermometer-to-binary encoder.
package thermo_enc_pkg;

    localparam int IN_W_DEF = 256;
    localparam int GRP_W    = 16;
    localparam int N_GRP    = IN_W_DEF / GRP_W;

    typedef logic [7:0]          code_t;
    typedef logic [IN_W_DEF-1:0] therm_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/prio_enc_16x4.sv
// Combinational 16-bit priority encoder: highest set bit index plus "any bit set" flag.
module prio_enc_16x4 (
    input  logic [15:0] vec,
    output logic        any,
    output logic [3:0]  idx
);

    always_comb begin
        // NOTE: default assignment first so no path leaves idx unassigned (no latch).
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) idx = 4'(i);
        end
        any = |vec;
    end

endmodule

// File: rtl/thermo_encoder_256x8.sv
// Registered 256-to-8 priority encoder for the flash ADC back end.
// Define THERMO_ENC_BUBBLE_FIX_EN to insert 3-input majority bubble correction ahead of the encoder.
module thermo_encoder_256x8
    import thermo_enc_pkg::*;
#(
    parameter  int IN_W  = IN_W_DEF,
    localparam int OUT_W = $clog2(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [IN_W-1:0]  data_in,
    output logic [OUT_W-1:0] encoded_out,
    output logic             valid
);

    if (IN_W < 2 || IN_W > IN_W_DEF || (IN_W & (IN_W - 1)) != 0) begin : g_bad_width
        $error("thermo_encoder_256x8: IN_W must be a power of two in 2..256");
    end

    logic [IN_W-1:0]  shaped;
    therm_t           grp_in;
    logic [N_GRP-1:0] grp_any;
    logic [3:0]       grp_idx [N_GRP];
    logic             top_any;
    logic [3:0]       top_grp;
    code_t            code;

`ifdef THERMO_ENC_BUBBLE_FIX_EN
    // Virtual neighbours: a 1 below bit 0 and a 0 above the top bit.
    logic [IN_W+1:0] ext;
    assign ext = {1'b0, data_in, 1'b1};

    always_comb begin
        shaped = '0;
        for (int i = 0; i < IN_W; i++) begin
            shaped[i] = maj3(ext[i], ext[i+1], ext[i+2]);
        end
    end
`else
    assign shaped = data_in;
`endif

    always_comb begin
        grp_in             = '0;
        grp_in[IN_W-1:0]   = shaped;
    end

    for (genvar g = 0; g < N_GRP; g++) begin : g_grp
        prio_enc_16x4 u_grp (
            .vec (grp_in[g*GRP_W +: GRP_W]),
            .any (grp_any[g]),
            .idx (grp_idx[g])
        );
    end

    prio_enc_16x4 u_top (
        .vec (grp_any),
        .any (top_any),
        .idx (top_grp)
    );

    // An all-zero input lands on group 0 with local index 0, giving code 0.
    assign code = {top_grp, grp_idx[top_grp]};

    logic [OUT_W-1:0] encoded_q, encoded_d;
    logic             valid_q,   valid_d;

    always_comb begin
        encoded_d = encoded_q;
        valid_d   = valid_q;
        if (en) begin
            encoded_d = code[OUT_W-1:0];
            valid_d   = top_any;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            encoded_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            encoded_q <= encoded_d;
            valid_q   <= valid_d;
        end
    end

    assign encoded_out = encoded_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_thermo_encoder_256x8.sv
// Scoreboard bench for thermo_encoder_256x8 against a behavioural reference model.
module tb_thermo_encoder_256x8;
    import thermo_enc_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   en;
    therm_t data_in;
    code_t  encoded_out;
    logic   valid;

    thermo_encoder_256x8 #(.IN_W(256)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .data_in     (data_in),
        .encoded_out (encoded_out),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        code_t code;
        logic  valid;
        string name;
    } exp_t;

    exp_t  sb[$];
    int    vectors     = 0;
    int    miscompares = 0;

    code_t model_code  = '0;
    logic  model_valid = 1'b0;

    function automatic therm_t ref_shape(input therm_t d);
        therm_t s;
        s = d;
`ifdef THERMO_ENC_BUBBLE_FIX_EN
        for (int i = 0; i < 256; i++) begin
            int votes;
            votes = int'(d[i]);
            votes += (i == 0)   ? 1 : int'(d[i-1]);
            votes += (i == 255) ? 0 : int'(d[i+1]);
            s[i] = (votes >= 2);
        end
`endif
        return s;
    endfunction

    function automatic int ref_top(input therm_t d);
        for (int k = 255; k >= 0; k--) begin
            if (d[k]) return k;
        end
        return -1;
    endfunction

    task automatic step(input logic r, input logic e, input therm_t d, input string name);
        int   top;
        exp_t x;
        @(negedge clk);
        rst_n   = r;
        en      = e;
        data_in = d;
        if (!r) begin
            model_code  = '0;
            model_valid = 1'b0;
        end else if (e) begin
            top         = ref_top(ref_shape(d));
            model_valid = (top >= 0);
            model_code  = (top >= 0) ? code_t'(top) : '0;
        end
        x.code  = model_code;
        x.valid = model_valid;
        x.name  = name;
        sb.push_back(x);
    endtask

    function automatic therm_t thermo(input int k);
        therm_t t;
        t = '0;
        for (int i = 0; i <= k; i++) t[i] = 1'b1;
        return t;
    endfunction

    function automatic therm_t rand_vec();
        therm_t t;
        for (int w = 0; w < 8; w++) t[w*32 +: 32] = $urandom();
        return t;
    endfunction

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                vectors++;
                if ({valid, encoded_out} !== {x.valid, x.code}) begin
                    miscompares++;
                    $display("FAIL %s: got code=%0d valid=%b, want code=%0d valid=%b",
                             x.name, encoded_out, valid, x.code, x.valid);
                end
            end
        end
    end

    initial begin : stimulus
        therm_t ones;
        therm_t v;
        ones    = '1;
        rst_n   = 1'b0;
        en      = 1'b0;
        data_in = '0;

        step(1'b0, 1'b1, ones, "reset_hold0");
        step(1'b0, 1'b1, ones, "reset_hold1");
        step(1'b1, 1'b1, ones, "reset_release");

        v = '0; v[0] = 1'b1;
        step(1'b1, 1'b1, v,  "single_low_bit");
        step(1'b1, 1'b1, '0, "all_zero");

        for (int k = 0; k < 256; k++) begin
            v = '0; v[k] = 1'b1;
            step(1'b1, 1'b1, v, $sformatf("walk_%0d", k));
        end

        for (int k = 0; k < 256; k++) begin
            step(1'b1, 1'b1, thermo(k), $sformatf("thermo_%0d", k));
        end

        v = thermo(99); v[200] = 1'b1;
        step(1'b1, 1'b1, v, "bubble_200_over_99");

        step(1'b1, 1'b1, therm_t'(8'h0F), "enable_load_0f");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, ones, $sformatf("enable_hold_%0d", i));
        step(1'b1, 1'b1, ones, "enable_resume");

        for (int n = 0; n < 400; n++) begin
            logic r, e;
            int   mode;
            r    = ($urandom_range(99) >= 3);
            e    = ($urandom_range(99) >= 20);
            mode = $urandom_range(4);
            case (mode)
                0: v = rand_vec();
                1: v = thermo($urandom_range(255));
                2: begin
                    v = thermo($urandom_range(255));
                    v[$urandom_range(255)] = ~v[$urandom_range(255)];
                    v[$urandom_range(255)] = 1'b1;
                end
                3: begin
                    v = '0;
                    v[$urandom_range(255)] = 1'b1;
                end
                default: v = '0;
            endcase
            step(r, e, v, $sformatf("random_%0d", n));
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/thermo_encoder_256x8.md
Name: thermo_encoder_256x8

Overview:
- Registered 256-to-8 priority encoder for the 8-bit flash ADC back end.
- Takes the 256-bit comparator (thermometer) vector and outputs the index of the highest asserted bit as an 8-bit binary code.
- Sits directly after the comparator bank and feeds the ADC output register and downstream logic.
- Also flags the all-zero input condition.

Parameters:
- IN_W, 256, comparator vector width. Must be a power of two, at most 256.
- OUT_W, 8, output code width. Fixed at $clog2(IN_W); not independently overridable.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
- en  input  1  sample enable. When high, the input is encoded and registered this cycle.
- data_in  input  IN_W  comparator/thermometer vector; bit i high means level i was exceeded.
- encoded_out  output  OUT_W  index of the highest set bit of data_in, registered.
- valid  output  1  registered; high when the sampled data_in had at least one bit set.

Behaviour:
- Reset:
  - rst_n low at a rising edge of clk forces encoded_out = 0 and valid = 0.
  - Reset overrides en.
  - Asserting reset mid-stream discards any in-flight sample.
- Encode function:
  - encoded_out = largest i such that data_in[i] = 1.
  - Highest index wins regardless of lower bits, so bubbles below the top bit are ignored.
  - data_in = 0 gives encoded_out = 0 and valid = 0.
  - data_in[0] only gives encoded_out = 0 and valid = 1; valid disambiguates this from the all-zero case.
- Latency:
  - Exactly one clock cycle.
  - data_in sampled at edge N with en = 1 appears on encoded_out/valid immediately after edge N.
  - No combinational path from data_in to any output.
- Enable:
  - en = 0 holds encoded_out and valid at their previous values.
  - data_in is ignored while en = 0.
- Width rules:
  - Output is a plain unsigned binary code in 0..IN_W-1.
  - All-ones input gives IN_W-1 (255).
- Timing structure:
  - Combinational encoder built as a log-depth tree of 16-bit groups.
  - Each group produces a "group has any bit set" flag and a 4-bit local index.
  - Top level selects the highest non-empty group and concatenates the group number with its local index.
- No handshake and no state machine beyond the output register.

Optional Feature:
- Macro: THERMO_ENC_BUBBLE_FIX_EN
- Defined:
  - Before priority encoding, each bit is replaced by a 3-input majority of data_in[i-1], data_in[i], data_in[i+1].
  - Out-of-range neighbours are taken as 1 below bit 0 and 0 above bit IN_W-1.
  - This suppresses isolated single-bit bubbles and sparkles from comparator metastability.
  - Latency remains one cycle; the correction is combinational ahead of the register.
- Undefined:
  - data_in feeds the priority encoder directly.
  - An isolated high bit at index k produces encoded_out = k if it is the topmost set bit.

Decomposition:
- Package thermo_enc_pkg:
  - Constants IN_W_DEF = 256, GRP_W = 16, N_GRP = IN_W_DEF/GRP_W.
  - Typedefs code_t (logic [7:0]) and therm_t (logic [255:0]).
- Sub-module prio_enc_16x4:
  - Combinational 16-bit priority encoder with outputs any (1 bit) and idx (4 bits).
  - Instantiated N_GRP times for the group stage, and reused once on the 16 group "any" flags for the top-level select.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with data_in = all-ones and en = 1 -> encoded_out = 0, valid = 0 throughout. Release -> next edge gives encoded_out = 255, valid = 1.
- Single low bit: data_in = 256'h1, en = 1 -> one cycle later encoded_out = 0, valid = 1. Then data_in = 0 -> encoded_out = 0, valid = 0.
- Walking one: data_in = 1<<k for k = 0..255 (macro undefined) -> encoded_out = k with valid = 1, each one cycle after its input.
- Thermometer sweep: data_in = (1<<(k+1))-1 for k = 0..255 -> encoded_out = k. Cover group boundaries k = 15, 16, 255.
- Bubble and priority:
  - data_in bits 0..99 set plus bit 200 set, macro undefined -> encoded_out = 200.
  - Same input with THERMO_ENC_BUBBLE_FIX_EN defined -> encoded_out = 99.
- Enable hold: encode 0x0F (-> 3), then en = 0 with data_in = all-ones for 5 cycles -> encoded_out stays 3. Set en = 1 -> encoded_out = 255 the next cycle.
